ultrasonido_multicanal: RTL
===========================

Name: ultrasonido_multicanal

Overview:
Parametrised multi-channel ultrasonic ranging controller. It replaces the single-channel free-running trigger/echo counter.
- Sequences NUM_CH HC-SR04-class sensors round-robin so only one sensor fires at a time (no crosstalk).
- Measures echo pulse width in clock cycles.
- Detects no-echo and over-range.
- Supports continuous or single-shot sweeps.
- Sits between the sensor GPIO pins and the NIOS II PIO/Avalon register bank.

Parameters:
DATAWIDTH, 16, width of each channel's echo-width result.
NUM_CH, 4, number of sensors (1..16).
CH_W, 2, channel index width; must be at least clog2(NUM_CH), minimum 1.
TIMER_W, 24, width of the internal phase timer.
TRIG_CYCLES, 500, trigger pulse high time in clocks (10 us at 50 MHz).
WAIT_TIMEOUT, 50000, maximum clocks from trigger end to echo rise.
HOLDOFF_CYCLES, 3000000, idle gap after each channel (60 ms at 50 MHz).

Ports:
Ultrasonido_Clock  in  1  system clock.
Ultrasonido_Reset  in  1  synchronous, active-high reset.
Ultrasonido_Enable_In  in  1  1 = sequencer allowed to run.
Ultrasonido_Mode_In  in  1  0 = continuous sweeps, 1 = single-shot sweep.
Ultrasonido_Start_In  in  1  single-cycle pulse that starts a single-shot sweep.
Ultrasonido_Echo_In  in  NUM_CH  raw asynchronous echo lines.
Ultrasonido_Trigger_Out  out  NUM_CH  trigger lines, one-hot or zero.
Ultrasonido_Conteo_Out  out  NUM_CH*DATAWIDTH  packed results; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH].
Ultrasonido_Timeout_Out  out  NUM_CH  per-channel flag: last result invalid (no echo or saturated).
Ultrasonido_Valid_Out  out  1  one-cycle pulse when a channel result updates.
Ultrasonido_Canal_Out  out  CH_W  channel of the current or last measurement.
Ultrasonido_Busy_Out  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: single clock domain; every register is reset synchronously.
- Reset values: Trigger 0, Conteo 0, Timeout 0, Valid 0, Canal 0, Busy 0, FSM IDLE, timers 0.
- Reset mid-operation: outputs reach reset values at the first clock edge with Reset high; any partial measurement is discarded.
- Echo synchronisation: each Echo_In bit passes through a 2-flop synchroniser. Only the selected channel's synchronised bit (echo_s) is used; a registered copy provides edge detection.
- IDLE:
  - Mode=0 and Enable=1: go to TRIG with ch=0.
  - Mode=1, Enable=1 and Start=1: go to TRIG with ch=0.
  - Start pulses outside IDLE are ignored.
- TRIG: Trigger_Out[ch]=1 for exactly TRIG_CYCLES clocks, then go to WAIT.
- WAIT:
  - Rising edge of echo_s: go to MEAS with count=0.
  - Timer reaches WAIT_TIMEOUT first: result = all ones, Timeout[ch]=1, Valid pulse, go to HOLD.
- MEAS:
  - count increments on each clock that echo_s is high.
  - Falling edge of echo_s: Conteo[ch]=count, Timeout[ch]=0, Valid=1 in that same cycle, go to HOLD. Result N equals the number of cycles echo_s was high.
  - Saturation: if count reaches 2^DATAWIDTH-1 while echo is still high, store all ones, Timeout[ch]=1, Valid pulse, go to HOLD. The remainder of the echo is ignored.
- HOLD: wait HOLDOFF_CYCLES, then:
  - ch < NUM_CH-1: ch+1, go to TRIG.
  - Last channel, Mode=0 and Enable=1: ch=0, go to TRIG.
  - Otherwise: go to IDLE.
- Enable deassertion: takes effect only at the HOLD exit (channel boundary); Trigger_Out is never truncated.
- Channel index: Canal_Out tracks ch throughout and stays at the last channel in IDLE.
- Stale results: Conteo and Timeout for channels not being measured hold their values.
- Simultaneous events: a rising and falling edge cannot occur in the same cycle on one channel. In WAIT, an echo edge in the same cycle as the timeout takes priority over the timeout.
- Echo already high on WAIT entry: no rising edge is seen, so the channel times out.
- Phase timer: TIMER_W bits, reset to 0 on every state change. Elaboration asserts that TRIG_CYCLES, WAIT_TIMEOUT and HOLDOFF_CYCLES are each < 2^TIMER_W and that NUM_CH <= 2^CH_W.

Decomposition:
- Package ultrasonido_pkg: FSM state encoding (IDLE, TRIG, WAIT, MEAS, HOLD) and default timing constants for 50 MHz.
- One sub-module, ultrasonido_sync: parametrised-width 2-flop synchroniser, instantiated once NUM_CH wide.
- Top level contains the FSM, phase timer, pulse counter and result registers.

Test Plan:
(All scenarios use NUM_CH=2, DATAWIDTH=8, TRIG_CYCLES=4, WAIT_TIMEOUT=20, HOLDOFF_CYCLES=6, Mode=0.)
- Basic measurement: Enable=1, echo0 rises 5 clocks after trigger end and stays high 37 clocks -> Trigger_Out=01 for exactly 4 clocks; Conteo[7:0]=37, Timeout[0]=0, Valid pulses once with Canal=0; Trigger_Out=10 follows 6 clocks after HOLD entry.
- No echo: echo1 held low -> after 20 WAIT clocks Conteo[15:8]=255, Timeout[1]=1, Valid pulses with Canal=1.
- Saturation: echo0 held high 300 clocks -> Conteo[7:0]=255, Timeout[0]=1, single Valid pulse; the late falling edge produces no second Valid.
- Single-shot sweep: Mode=1, Start pulsed once -> exactly two Valid pulses (Canal 0 then 1), then Busy=0 and Trigger_Out=00; a Start pulse while Busy=1 has no effect.
- Reset mid-operation: Reset asserted in MEAS (count=12) -> next edge gives Trigger 0, Conteo 0, Busy 0; after release with Enable=1 the sweep restarts at channel 0.
- Enable drop: Enable=0 during TRIG of channel 0 -> the trigger completes its 4 clocks and channel 0 is measured; at HOLD exit the FSM returns to IDLE and channel 1 is never triggered.

Source files
------------

// File: rtl/ultrasonido_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranging controller:
// sequencer state encoding and default timing constants for a 50 MHz clock.
package ultrasonido_pkg;

  // Sequencer phases. One sensor at a time walks TRIG -> WAIT -> MEAS -> HOLD.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_MEAS = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  // Defaults for 50 MHz operation.
  localparam int DEF_DATAWIDTH      = 16;
  localparam int DEF_NUM_CH         = 4;
  localparam int DEF_CH_W           = 2;
  localparam int DEF_TIMER_W        = 24;
  localparam int DEF_TRIG_CYCLES    = 500;      // 10 us trigger pulse
  localparam int DEF_WAIT_TIMEOUT   = 50000;    // 1 ms for the echo to start
  localparam int DEF_HOLDOFF_CYCLES = 3000000;  // 60 ms between channels

  // True when 'value' can be held in an unsigned field of 'width' bits.
  function automatic bit fits_in(input longint value, input int width);
    return (value >= 0) && (value < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/ultrasonido_sync.sv
// Two-flop synchroniser for a bundle of independent asynchronous lines.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
module ultrasonido_sync
  import ultrasonido_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             Ultrasonido_Clock,
  input  logic             Ultrasonido_Reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge Ultrasonido_Clock) begin
    if (Ultrasonido_Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/ultrasonido_multicanal.sv
// Round-robin controller for NUM_CH HC-SR04-class ultrasonic sensors.
// Only one sensor is triggered at a time; its echo pulse width is measured
// in clock cycles and stored in that channel's slot of the packed result bus.
//
// Output handshake: Ultrasonido_Valid_Out is a one-cycle pulse with no ready
// back-pressure. In the cycle it is high, Ultrasonido_Canal_Out names the
// channel just written, and that channel's Conteo slice and Timeout bit
// already hold the new result. Results persist until the channel is measured
// again, so a slow reader can still sample them after the pulse.
module ultrasonido_multicanal
  import ultrasonido_pkg::*;
#(
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CH_W           = DEF_CH_W,
  parameter int TIMER_W        = DEF_TIMER_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int WAIT_TIMEOUT   = DEF_WAIT_TIMEOUT,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic                        Ultrasonido_Clock,
  input  logic                        Ultrasonido_Reset,
  input  logic                        Ultrasonido_Enable_In,
  input  logic                        Ultrasonido_Mode_In,
  input  logic                        Ultrasonido_Start_In,
  input  logic [NUM_CH-1:0]           Ultrasonido_Echo_In,
  output logic [NUM_CH-1:0]           Ultrasonido_Trigger_Out,
  output logic [NUM_CH*DATAWIDTH-1:0] Ultrasonido_Conteo_Out,
  output logic [NUM_CH-1:0]           Ultrasonido_Timeout_Out,
  output logic                        Ultrasonido_Valid_Out,
  output logic [CH_W-1:0]             Ultrasonido_Canal_Out,
  output logic                        Ultrasonido_Busy_Out
);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..16");
  end
  if (CH_W < 1 || longint'(NUM_CH) > (longint'(1) << CH_W)) begin : g_bad_ch_w
    $error("CH_W must be at least 1 and wide enough to index NUM_CH channels");
  end
  if (TRIG_CYCLES < 1 || !fits_in(longint'(TRIG_CYCLES), TIMER_W)) begin : g_bad_trig
    $error("TRIG_CYCLES must be >= 1 and < 2**TIMER_W");
  end
  if (WAIT_TIMEOUT < 1 || !fits_in(longint'(WAIT_TIMEOUT), TIMER_W)) begin : g_bad_wait
    $error("WAIT_TIMEOUT must be >= 1 and < 2**TIMER_W");
  end
  if (HOLDOFF_CYCLES < 1 || !fits_in(longint'(HOLDOFF_CYCLES), TIMER_W)) begin : g_bad_hold
    $error("HOLDOFF_CYCLES must be >= 1 and < 2**TIMER_W");
  end

  // Terminal timer values: a phase of N clocks occupies timer values 0..N-1.
  localparam logic [TIMER_W-1:0]   TRIG_LAST = TIMER_W'(TRIG_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   WAIT_LAST = TIMER_W'(WAIT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0]   HOLD_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CH_W-1:0]      CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [DATAWIDTH-1:0] COUNT_MAX = '1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                      state_q;
  logic [TIMER_W-1:0]          timer_q;
  logic [DATAWIDTH-1:0]        count_q;
  logic [CH_W-1:0]             ch_q;
  logic [NUM_CH-1:0]           trigger_q;
  logic [NUM_CH-1:0]           timeout_q;
  logic [NUM_CH*DATAWIDTH-1:0] conteo_q;
  logic                        valid_q;
  logic                        busy_q;

  logic [NUM_CH-1:0] echo_sync;
  logic              echo_s;
  logic              echo_d;
  logic              echo_rise;
  logic              echo_fall;
  int                slot_lsb;

  ultrasonido_sync #(
    .WIDTH (NUM_CH)
  ) u_echo_sync (
    .Ultrasonido_Clock (Ultrasonido_Clock),
    .Ultrasonido_Reset (Ultrasonido_Reset),
    .async_in          (Ultrasonido_Echo_In),
    .sync_out          (echo_sync)
  );

  // Only the channel being sequenced matters. The channel index changes at
  // HOLD exit, and TRIG lasts at least one clock, so echo_d has re-settled on
  // the new channel before WAIT starts looking for edges.
  assign echo_s    = echo_sync[ch_q];
  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;
  assign slot_lsb  = int'(ch_q) * DATAWIDTH;

  // Delayed copy of the selected echo for edge detection.
  always_ff @(posedge Ultrasonido_Clock) begin
    if (Ultrasonido_Reset) begin
      echo_d <= 1'b0;
    end else begin
      echo_d <= echo_s;
    end
  end

  // Sequencer: phase timer, pulse counter, trigger lines and result registers.
  always_ff @(posedge Ultrasonido_Clock) begin
    if (Ultrasonido_Reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      ch_q      <= '0;
      trigger_q <= '0;
      timeout_q <= '0;
      conteo_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          // Continuous mode free-runs while enabled; single-shot waits for Start.
          if (Ultrasonido_Enable_In && (!Ultrasonido_Mode_In || Ultrasonido_Start_In)) begin
            state_q   <= ST_TRIG;
            ch_q      <= '0;
            trigger_q <= NUM_CH'(1);
            busy_q    <= 1'b1;
          end
        end

        ST_TRIG: begin
          if (timer_q == TRIG_LAST) begin
            state_q   <= ST_WAIT;
            timer_q   <= '0;
            trigger_q <= '0;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        ST_WAIT: begin
          // An edge arriving on the timeout cycle still counts as an echo.
          if (echo_rise) begin
            state_q <= ST_MEAS;
            timer_q <= '0;
            // The rising-edge cycle is itself the first high cycle of the echo.
            count_q <= DATAWIDTH'(1);
          end else if (timer_q == WAIT_LAST) begin
            state_q                              <= ST_HOLD;
            timer_q                              <= '0;
            conteo_q[slot_lsb +: DATAWIDTH]      <= COUNT_MAX;
            timeout_q[ch_q]                      <= 1'b1;
            valid_q                              <= 1'b1;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        ST_MEAS: begin
          if (echo_fall) begin
            state_q                         <= ST_HOLD;
            timer_q                         <= '0;
            conteo_q[slot_lsb +: DATAWIDTH] <= count_q;
            timeout_q[ch_q]                 <= 1'b0;
            valid_q                         <= 1'b1;
          end else if (echo_s) begin
            // Full counter and echo still high: report over-range and move on;
            // the tail of this echo is never looked at.
            if (count_q == COUNT_MAX) begin
              state_q                         <= ST_HOLD;
              timer_q                         <= '0;
              conteo_q[slot_lsb +: DATAWIDTH] <= COUNT_MAX;
              timeout_q[ch_q]                 <= 1'b1;
              valid_q                         <= 1'b1;
            end else begin
              count_q <= count_q + DATAWIDTH'(1);
            end
          end
        end

        ST_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            timer_q <= '0;
            // Enable is only honoured here, so a dropped enable never cuts a
            // trigger pulse or a measurement short.
            if (!Ultrasonido_Enable_In) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else if (ch_q != CH_LAST) begin
              state_q   <= ST_TRIG;
              ch_q      <= ch_q + CH_W'(1);
              trigger_q <= NUM_CH'(1) << (ch_q + CH_W'(1));
            end else if (!Ultrasonido_Mode_In) begin
              state_q   <= ST_TRIG;
              ch_q      <= '0;
              trigger_q <= NUM_CH'(1);
            end else begin
              // Single-shot sweep done; Canal keeps pointing at the last channel.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          timer_q   <= '0;
          trigger_q <= '0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Ultrasonido_Trigger_Out = trigger_q;
  assign Ultrasonido_Conteo_Out  = conteo_q;
  assign Ultrasonido_Timeout_Out = timeout_q;
  assign Ultrasonido_Valid_Out   = valid_q;
  assign Ultrasonido_Canal_Out   = ch_q;
  assign Ultrasonido_Busy_Out    = busy_q;

endmodule
